// File: rtl/asmd_mult_sequencer.sv
// Operand FIFO and issue/collect sequencer sitting in front of the ASMD shift-add multiplier.
// One multiplication in flight at a time; a held result blocks further issues.
module asmd_mult_sequencer #(
    parameter int word_length  = 4,
    parameter int fifo_depth   = 4,
    parameter int busy_timeout = 15
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [word_length-1:0]         in_word0,
    input  logic [word_length-1:0]         in_word1,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [2*word_length-1:0]       out_product,
    output logic [word_length-1:0]         mult_word0,
    output logic [word_length-1:0]         mult_word1,
    output logic                           mult_start,
    input  logic                           mult_ready,
    input  logic [2*word_length-1:0]       mult_product,
    output logic [$clog2(fifo_depth):0]    fifo_count,
    output logic                           timeout_err
);

    localparam int aw = $clog2(fifo_depth);
    localparam int cw = $clog2(busy_timeout + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HOLD} state_t;

    state_t state, state_next;

    logic [word_length-1:0] mem0 [fifo_depth];
    logic [word_length-1:0] mem1 [fifo_depth];
    logic [aw-1:0]          wr_ptr, rd_ptr;
    logic [aw:0]            count;
    logic [cw-1:0]          wait_cnt;
    logic                   push, pop, timeout_hit, capture;

    assign in_ready    = (count != (aw+1)'(fifo_depth));
    assign fifo_count  = count;
    assign push        = in_valid && in_ready;
    assign pop         = (state == IDLE) && (count != '0) && mult_ready && !out_valid;
    assign timeout_hit = (state == WAIT_BUSY) && mult_ready && (wait_cnt == cw'(busy_timeout - 1));
    assign capture     = (state == WAIT_DONE) && mult_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        mult_start = 1'b0;
        case (state)
            IDLE:      if (pop) state_next = ISSUE;
            ISSUE: begin
                mult_start = 1'b1;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!mult_ready)      state_next = WAIT_DONE;
                else if (timeout_hit) state_next = IDLE;
            end
            WAIT_DONE: if (mult_ready) state_next = HOLD;
            HOLD:      if (out_valid && out_ready) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Storage has no reset; only the pointers and count define occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem0[wr_ptr] <= in_word0;
            mem1[wr_ptr] <= in_word1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            mult_word0  <= '0;
            mult_word1  <= '0;
            out_valid   <= 1'b0;
            out_product <= '0;
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                mult_word0 <= mem0[rd_ptr];
                mult_word1 <= mem1[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (state == ISSUE)          wait_cnt <= '0;
            else if (state == WAIT_BUSY) wait_cnt <= wait_cnt + 1'b1;

            if (timeout_hit) timeout_err <= 1'b1;

            if (capture) begin
                out_product <= mult_product;
                out_valid   <= 1'b1;
            end else if ((state == HOLD) && out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_asmd_mult_sequencer.sv
// Scoreboard bench for asmd_mult_sequencer with a behavioural shift-add multiplier model.
module tb_asmd_mult_sequencer;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_word0 = '0;
    logic [W-1:0]   in_word1 = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*W-1:0] out_product;
    logic [W-1:0]   mult_word0, mult_word1;
    logic           mult_start;
    logic           mult_ready;
    logic [2*W-1:0] mult_product;
    logic [2:0]     fifo_count;
    logic           timeout_err;

    int checks = 0;
    int errors = 0;
    int starts = 0;
    int valid_cycles = 0;
    bit noready = 1'b0;
    bit done6 = 1'b0;
    logic [2*W-1:0] q[$];

    logic [2:0]     m_busy;
    logic           m_ready;
    logic [2*W-1:0] m_prod;
    logic [W-1:0]   rec_w0, rec_w1;

    assign mult_ready   = m_ready;
    assign mult_product = m_prod;

    asmd_mult_sequencer #(.word_length(W), .fifo_depth(4), .busy_timeout(15)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_word0(in_word0), .in_word1(in_word1),
        .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
        .mult_word0(mult_word0), .mult_word1(mult_word1), .mult_start(mult_start),
        .mult_ready(mult_ready), .mult_product(mult_product),
        .fifo_count(fifo_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Ready drops the edge after start and rises four edges later; noready ignores start.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ready <= 1'b1;
            m_busy  <= '0;
            m_prod  <= '0;
            rec_w0  <= '0;
            rec_w1  <= '0;
        end else if (mult_start && !noready) begin
            m_ready <= 1'b0;
            m_busy  <= 3'd4;
            m_prod  <= {{W{1'b0}}, mult_word0} * {{W{1'b0}}, mult_word1};
            rec_w0  <= mult_word0;
            rec_w1  <= mult_word1;
        end else if (m_busy != 0) begin
            m_busy <= m_busy - 1'b1;
            if (m_busy == 3'd1) m_ready <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (mult_start) begin
                starts++;
                chk("start_while_valid", {31'd0, out_valid}, 32'd0);
            end
            if (out_valid) valid_cycles++;
            if (m_busy != 0) chk("words_stable", {24'd0, mult_word0, mult_word1}, {24'd0, rec_w0, rec_w1});
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_product: got %0d expected none", out_product);
                end else begin
                    chk("product", {24'd0, out_product}, {24'd0, q.pop_front()});
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_it);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_word0 = a;
        in_word1 = b;
        n = 0;
        while (!in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (expect_it) q.push_back({{W{1'b0}}, a} * {{W{1'b0}}, b});
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_valid(input int limit);
        int n;
        n = 0;
        while (!out_valid && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("wait_valid", {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        int s0, v0, n;
        bit seen;
        logic [W-1:0] va [10];
        logic [W-1:0] vb [10];

        // reset state
        #2;
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_start", {31'd0, mult_start}, 0);
        chk("rst_count", {29'd0, fifo_count}, 0);
        chk("rst_words", {24'd0, mult_word0, mult_word1}, 0);
        chk("rst_timeout", {31'd0, timeout_err}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // single pair
        s0 = starts; v0 = valid_cycles;
        send(4'd13, 4'd11, 1'b1);
        drain(100);
        chk("t2_starts", starts - s0, 1);
        chk("t2_valid_cycles", valid_cycles - v0, 1);
        chk("t2_product_hold", {24'd0, out_product}, 143);

        // backpressure with a full FIFO
        out_ready = 1'b0;
        s0 = starts;
        send(4'd15, 4'd15, 1'b1);
        send(4'd1, 4'd2, 1'b1);
        send(4'd3, 4'd4, 1'b1);
        send(4'd5, 4'd6, 1'b1);
        send(4'd7, 4'd8, 1'b1);
        wait_valid(100);
        chk("t3_count_full", {29'd0, fifo_count}, 4);
        chk("t3_in_ready", {31'd0, in_ready}, 0);
        repeat (20) @(negedge clk);
        chk("t3_held_valid", {31'd0, out_valid}, 1);
        chk("t3_held_product", {24'd0, out_product}, 225);
        chk("t3_one_start", starts - s0, 1);
        out_ready = 1'b1;
        drain(500);

        // simultaneous push and pop at count 2, then wrap over 10 pairs
        va = '{4'd2, 4'd0, 4'd15, 4'd9, 4'd6, 4'd1, 4'd12, 4'd8, 4'd3, 4'd14};
        vb = '{4'd5, 4'd0, 4'd1, 4'd9, 4'd7, 4'd1, 4'd10, 4'd15, 4'd13, 4'd2};
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(va[i], vb[i], 1'b1);
        wait_valid(100);
        chk("t4_count_before", {29'd0, fifo_count}, 2);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        send(va[3], vb[3], 1'b1);
        chk("t4_count_same", {29'd0, fifo_count}, 2);
        for (int i = 4; i < 10; i++) send(va[i], vb[i], 1'b1);
        drain(500);

        // multiplier that never goes busy
        noready = 1'b1;
        s0 = starts;
        send(4'd4, 4'd4, 1'b0);
        n = 0;
        while (!timeout_err && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        chk("t5_timeout_latency", n, 17);
        chk("t5_timeout_err", {31'd0, timeout_err}, 1);
        repeat (2) @(negedge clk);
        noready = 1'b0;
        send(4'd9, 4'd7, 1'b1);
        drain(100);
        chk("t5_starts", starts - s0, 2);
        chk("t5_sticky", {31'd0, timeout_err}, 1);

        // random traffic with random backpressure
        done6 = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++)
                    send(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'b1);
                drain(5000);
                done6 = 1'b1;
            end
            begin
                while (!done6) begin
                    @(negedge clk);
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // reset mid-WAIT_DONE with one operand still buffered
        send(4'd2, 4'd3, 1'b1);
        send(4'd4, 4'd5, 1'b1);
        n = 0;
        while (m_busy == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t1_reached_busy", {31'd0, (m_busy != 0)}, 1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        q.delete();
        chk("t1_out_valid", {31'd0, out_valid}, 0);
        chk("t1_product", {24'd0, out_product}, 0);
        chk("t1_words", {24'd0, mult_word0, mult_word1}, 0);
        chk("t1_start", {31'd0, mult_start}, 0);
        chk("t1_count", {29'd0, fifo_count}, 0);
        chk("t1_in_ready", {31'd0, in_ready}, 1);
        chk("t1_timeout", {31'd0, timeout_err}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid || mult_start) seen = 1'b1;
        end
        chk("t1_quiet_after", {31'd0, seen}, 0);
        chk("t1_count_after", {29'd0, fifo_count}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
